// File: rtl/prng_arbiter.sv
// Round-robin front end that shares one PRNG256 core among N_REQ requesters.
// Each grant consumes a unique nonce. The 256-bit result is returned with a one-cycle ack.
module prng_arbiter #(
    parameter int N_REQ   = 3,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    output logic [N_REQ-1:0]   ack_o,
    output logic [255:0]       data_o,
    output logic               busy_o,
    output logic               error_o,
    output logic               exhausted_o,
    output logic               prng_drdy_o,
    output logic [CNT_W-1:0]   prng_cnt_o,
    input  logic [255:0]       prng_dout_i,
    input  logic               prng_dvld_i
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      last_q, last_d;
    logic [CNT_W-1:0]   nonce_q, nonce_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [255:0]       data_q, data_d;
    logic               err_q, err_d;
    logic               exh_q, exh_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               drdy_q, drdy_d;
    logic               busy_q, busy_d;
    logic               consume_s;
    logic               found_s;
    logic [GW-1:0]      win_s;
    logic [GW-1:0]      idx_s;

    // Round-robin search starting one past the last grant.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx_s = GW'((int'(last_q) + i) % N_REQ);
            if (!found_s && req_i[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and datapath logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        nonce_d   = nonce_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        err_d     = err_q;
        exh_d     = exh_q;
        consume_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s && !err_q && !exh_q) begin
                    grant_d = win_s;
                    last_d  = win_s;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (prng_dvld_i) begin
                    data_d    = prng_dout_i;
                    consume_s = 1'b1;
                    state_d   = ST_DELIVER;
                end else if (tmo_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    consume_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DELIVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // The last nonce value is never followed by a wrap back to zero.
        if (consume_s) begin
            if (nonce_q == CNT_MAX) begin
                exh_d = 1'b1;
            end else begin
                nonce_d = nonce_q + CNT_W'(1);
            end
        end else begin
            nonce_d = nonce_d;
        end
        drdy_d = (state_d == ST_ISSUE);
        busy_d = (state_d != ST_IDLE);
        ack_d  = (state_d == ST_DELIVER) ? (ONE_HOT0 << grant_d) : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(N_REQ - 1);
            nonce_q <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            exh_q   <= 1'b0;
            ack_q   <= '0;
            drdy_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            nonce_q <= nonce_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            err_q   <= err_d;
            exh_q   <= exh_d;
            ack_q   <= ack_d;
            drdy_q  <= drdy_d;
            busy_q  <= busy_d;
        end
    end

    assign ack_o       = ack_q;
    assign data_o      = data_q;
    assign busy_o      = busy_q;
    assign error_o     = err_q;
    assign exhausted_o = exh_q;
    assign prng_drdy_o = drdy_q;
    assign prng_cnt_o  = nonce_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench for prng_arbiter, built with a 4-bit nonce so exhaustion is reachable.
module tb_prng_arbiter;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [2:0]   req_i;
    logic [2:0]   ack_o;
    logic [255:0] data_o;
    logic         busy_o;
    logic         error_o;
    logic         exhausted_o;
    logic         prng_drdy_o;
    logic [3:0]   prng_cnt_o;
    logic [255:0] prng_dout_i;
    logic         prng_dvld_i;

    int n_checks = 0;
    int n_errors = 0;

    prng_arbiter #(.N_REQ(3), .CNT_W(4), .TIMEOUT(64)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .ack_o       (ack_o),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .error_o     (error_o),
        .exhausted_o (exhausted_o),
        .prng_drdy_o (prng_drdy_o),
        .prng_cnt_o  (prng_cnt_o),
        .prng_dout_i (prng_dout_i),
        .prng_dvld_i (prng_dvld_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_i       = 3'b000;
        prng_dvld_i = 1'b0;
        prng_dout_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ack"},  ack_o, 0);
        check_eq({tag, "_data"}, data_o, 0);
        check_eq({tag, "_busy"}, busy_o, 0);
        check_eq({tag, "_err"},  error_o, 0);
        check_eq({tag, "_exh"},  exhausted_o, 0);
        check_eq({tag, "_drdy"}, prng_drdy_o, 0);
        check_eq({tag, "_cnt"},  prng_cnt_o, 0);
    endtask

    // Expects req_i already set and the DUT in (or about to enter) IDLE.
    task automatic do_txn(input logic [2:0] exp_ack, input logic [3:0] exp_cnt, input int dly,
                          input logic [255:0] word, input bit clr_req, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!seen) begin
                @(negedge clk);
                seen = prng_drdy_o;
            end
        end
        check_eq({tag, "_drdy_seen"}, seen, 1);
        if (seen) begin
            check_eq({tag, "_cnt"}, prng_cnt_o, exp_cnt);
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                if (k == 0) check_eq({tag, "_drdy_pulse"}, prng_drdy_o, 0);
            end
            prng_dvld_i = 1'b1;
            prng_dout_i = word;
            @(negedge clk);
            prng_dvld_i = 1'b0;
            check_eq({tag, "_ack"}, ack_o, exp_ack);
            check_eq({tag, "_data"}, data_o, word);
            if (clr_req) req_i = 3'b000;
            @(negedge clk);
            check_eq({tag, "_busy_low"}, busy_o, 0);
            check_eq({tag, "_ack_low"}, ack_o, 0);
        end
    endtask

    initial begin
        logic [255:0] w;
        logic [255:0] last_w;
        int           n;
        int           drdy_cnt;

        do_reset();
        check_reset_vals("rst");

        // Single request, dvld three cycles after drdy
        w = {32{8'hA5}};
        req_i = 3'b010;
        do_txn(3'b010, 4'd0, 3, w, 1'b1, "single");

        // All requesters held: grants rotate 0,1,2 with nonces 0..5
        do_reset();
        req_i = 3'b111;
        for (int i = 0; i < 6; i++) begin
            w = {8{32'hC0DE0000 + 32'(i)}};
            do_txn(3'b001 << (i % 3), 4'(i), 1, w, (i == 5), $sformatf("rr%0d", i));
        end
        last_w = {8{32'hC0DE0005}};

        // Spurious dvld in IDLE is ignored
        prng_dvld_i = 1'b1;
        prng_dout_i = {64{4'hF}};
        @(negedge clk);
        prng_dvld_i = 1'b0;
        check_eq("spur_ack", ack_o, 0);
        check_eq("spur_data", data_o, last_w);
        check_eq("spur_busy", busy_o, 0);
        @(negedge clk);
        check_eq("spur_ack2", ack_o, 0);

        // Requester drops during WAIT; ack still goes to it
        req_i = 3'b001;
        @(negedge clk);
        check_eq("drop_drdy", prng_drdy_o, 1);
        check_eq("drop_cnt", prng_cnt_o, 6);
        req_i = 3'b000;
        @(negedge clk);
        w = {16{16'h1234}};
        prng_dvld_i = 1'b1;
        prng_dout_i = w;
        @(negedge clk);
        prng_dvld_i = 1'b0;
        check_eq("drop_ack", ack_o, 3'b001);
        check_eq("drop_data", data_o, w);
        @(negedge clk);

        // Reset while in WAIT aborts and restarts nonces at 0
        req_i = 3'b010;
        @(negedge clk);
        check_eq("rw_drdy", prng_drdy_o, 1);
        check_eq("rw_cnt", prng_cnt_o, 7);
        @(negedge clk);
        rst_i = 1'b1;
        req_i = 3'b000;
        @(negedge clk);
        rst_i = 1'b0;
        check_reset_vals("rw");
        req_i = 3'b010;
        w = {32{8'h3C}};
        do_txn(3'b010, 4'd0, 1, w, 1'b1, "rw_new");

        // Timeout: 64 WAIT cycles, then sticky error and no further grants
        req_i = 3'b001;
        @(negedge clk);
        check_eq("tmo_drdy", prng_drdy_o, 1);
        check_eq("tmo_cnt", prng_cnt_o, 1);
        n = 0;
        while (busy_o && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 64) check_eq("tmo_err_early", error_o, 0);
            if (ack_o != 3'b000) check_eq("tmo_no_ack", ack_o, 0);
        end
        check_eq("tmo_len", n, 65);
        check_eq("tmo_err", error_o, 1);
        drdy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (prng_drdy_o || busy_o) drdy_cnt++;
        end
        check_eq("tmo_blocked", drdy_cnt, 0);
        check_eq("tmo_err_sticky", error_o, 1);

        // Exhaustion after 16 consumed nonces
        do_reset();
        check_eq("exh_err_clr", error_o, 0);
        req_i = 3'b111;
        for (int i = 0; i < 16; i++) begin
            w = {8{32'h5A5A0000 + 32'(i)}};
            do_txn(3'b001 << (i % 3), 4'(i), 1, w, (i == 15), $sformatf("ex%0d", i));
            if (i >= 14) check_eq($sformatf("ex%0d_flag", i), exhausted_o, (i == 15));
        end
        req_i = 3'b001;
        drdy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (prng_drdy_o || busy_o) drdy_cnt++;
        end
        check_eq("exh_blocked", drdy_cnt, 0);
        check_eq("exh_sticky", exhausted_o, 1);
        check_eq("exh_no_err", error_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
